lsu_pipe: RTL and testbench
===========================

// Module: lsu_pipe
// PURPOSE
//  Multi-cycle, parametrised load/store unit in the memory-access stage.
//  - Accepts one instruction per handshake from execute.
//  - Decodes RISC-V LOAD/STORE opcode and funct3.
//  - Runs a req/ack transaction on the data bus with byte-lane strobes.
//  - Aligns and sign/zero-extends load data; returns a result under rsp_valid/rsp_ready backpressure.
//  - Non-memory instructions bypass the bus: the ALU result goes straight to the response.
// PARAMETERS
//  XLEN         32  data width, 32 or 64; OFFW = $clog2(XLEN/8)
//  ADDR_W       32  address width
//  ACK_TIMEOUT  16  max cycles waiting for mem_ack; 0 = no timeout
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   1         instruction presented
//  req_ready  out  1         unit idle, can accept
//  req_instr  in   32        instruction word (opcode [6:0], funct3 [14:12])
//  req_addr   in   ADDR_W    effective address
//  req_wdata  in   XLEN      store data, or ALU result for non-memory ops
//  rsp_valid  out  1         result available
//  rsp_ready  in   1         consumer takes result
//  rsp_data   out  XLEN      load result, pass-through value, or 0
//  rsp_err    out  1         bad funct3, misaligned (no split), or timeout
//  mem_req    out  1         bus request
//  mem_we     out  1         1 = write
//  mem_addr   out  ADDR_W    word-aligned address (low OFFW bits = 0)
//  mem_be     out  XLEN/8    byte enables
//  mem_wdata  out  XLEN      lane-steered store data
//  mem_ack    in   1         bus completes current request
//  mem_rdata  in   XLEN      read data, valid with mem_ack
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1.
//    Reset takes effect mid-transaction too: mem_req drops immediately and the operation is lost.
//  - States: IDLE -> ACCESS [-> ACCESS2] -> RESP -> IDLE.
//  - req_ready=1 only in IDLE. Accept on req_valid&req_ready; latch instr, addr, wdata.
//  - Non-memory opcode: IDLE->RESP; rsp_data=req_wdata; rsp_valid in the cycle after accept.
//  - Invalid funct3: IDLE->RESP; rsp_err=1, rsp_data=0; no bus access.
//  - Legal funct3:
//    - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
//    - Stores: SB 000, SH 001, SW 010.
//    - XLEN=64 adds LD 011, LWU 110, SD 011.
//  - ACCESS: mem_req=1 from the cycle after accept. mem_addr, mem_we, mem_be and mem_wdata
//    stay constant until the cycle mem_ack=1 samples high. mem_ack is ignored while mem_req=0.
//  - Load latency: accept at T, mem_req at T+1, ack at T+k, rsp_valid at T+k+1.
//  - Lane steering, off = addr[OFFW-1:0]:
//    - mem_be = size mask << off.
//    - mem_wdata = store data << 8*off.
//    - Load data = mem_rdata >> 8*off, then sign-extended (signed ops) or zero-extended (U ops).
//  - Store response: rsp_data=0, rsp_err=0, issued after ack.
//  - Word-crossing access (off + size > XLEN/8): see CONFIGURATION.
//  - Timeout: counter clears on entering ACCESS/ACCESS2 and increments each cycle without ack.
//    When it reaches ACK_TIMEOUT: drop mem_req, go to RESP with rsp_err=1, rsp_data=0.
//    An ack in the same cycle as the count reaching ACK_TIMEOUT wins (normal completion).
//  - RESP: rsp_valid/rsp_data/rsp_err held stable until rsp_ready=1; then IDLE next cycle.
//    No new request is accepted in the same cycle rsp_ready is taken.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN
//  - Defined: a crossing access is split into two transactions.
//    - ACCESS at the aligned word with upper lanes.
//    - ACCESS2 at word+XLEN/8 with the remaining low lanes.
//    - Loads merge both reads before extension.
//    - A timeout in either phase gives rsp_err. The first store half is not rolled back.
//  - Undefined: a crossing access goes IDLE->RESP with rsp_err=1, rsp_data=0 and no mem_req.
// STRUCTURE
//  - Shared package lsu_pkg:
//    - opcode constants LOAD=7'b0000011, STORE=7'b0100011;
//    - funct3 constants;
//    - size enum (B/H/W/D);
//    - state enum (IDLE/ACCESS/ACCESS2/RESP).
//  - One sub-module, lsu_align (combinational): size/off -> mem_be, store steering,
//    load shift/merge/extension. The FSM and timeout counter stay in lsu_pipe.
// TESTING (XLEN=32)
//  1. LB addr 0x1003, mem_rdata 0x80000000 -> mem_addr 0x1000, mem_be 4'b1000, rsp_data 0xFFFFFF80.
//     LBU, same stimulus -> rsp_data 0x00000080.
//  2. SH addr 0x1002, req_wdata 0x0000BEEF -> mem_we 1, mem_be 4'b1100,
//     mem_wdata 0xBEEF0000, rsp_data 0.
//  3. LW with mem_ack delayed 3 cycles and rsp_ready low 2 cycles -> bus signals stable,
//     rsp_valid held, req_ready 0 until the cycle after rsp_ready.
//  4. ACK_TIMEOUT=8, LW, never ack -> mem_req drops after 8 wait cycles; rsp_err=1, rsp_data=0.
//  5. LW addr 0x1002, rdata 0xAABB0000 then 0x0000CCDD:
//     - with macro: accesses 0x1000 (be 1100) then 0x1004 (be 0011); rsp_data 0xCCDDAABB.
//     - without macro: rsp_err=1, mem_req never asserted.
//  6. rst_n low during ACCESS -> mem_req=0 immediately, req_ready=1.
//     After release, an R-type with req_wdata 0x1234 -> rsp_data 0x1234 in the cycle
//     after accept, no mem_req.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, opcode/funct3 constants and instruction decode for the load/store unit.
// Imported by lsu_align and lsu_pipe.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_ACCESS2 = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_store;
    logic  legal;
    size_e size;
    logic  sgn;
  } dec_t;

  // is64 enables the doubleword and LWU encodings.
  function automatic dec_t lsu_decode(input logic [31:0] instr, input logic is64);
    dec_t d;
    d = '0;
    d.size = SZ_B;
    case (instr[6:0])
      OP_LOAD: begin
        d.is_mem = 1'b1;
        case (instr[14:12])
          F3_B:    begin d.legal = 1'b1; d.size = SZ_B; d.sgn = 1'b1; end
          F3_H:    begin d.legal = 1'b1; d.size = SZ_H; d.sgn = 1'b1; end
          F3_W:    begin d.legal = 1'b1; d.size = SZ_W; d.sgn = 1'b1; end
          F3_D:    begin d.legal = is64; d.size = SZ_D; d.sgn = 1'b1; end
          F3_BU:   begin d.legal = 1'b1; d.size = SZ_B; d.sgn = 1'b0; end
          F3_HU:   begin d.legal = 1'b1; d.size = SZ_H; d.sgn = 1'b0; end
          F3_WU:   begin d.legal = is64; d.size = SZ_W; d.sgn = 1'b0; end
          default: begin d.legal = 1'b0; end
        endcase
      end
      OP_STORE: begin
        d.is_mem   = 1'b1;
        d.is_store = 1'b1;
        case (instr[14:12])
          F3_B:    begin d.legal = 1'b1; d.size = SZ_B; end
          F3_H:    begin d.legal = 1'b1; d.size = SZ_H; end
          F3_W:    begin d.legal = 1'b1; d.size = SZ_W; end
          F3_D:    begin d.legal = is64; d.size = SZ_D; end
          default: begin d.legal = 1'b0; end
        endcase
      end
      default: begin
        d.is_mem = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response and data-bus signals of the load/store unit.
// slave = the LSU's view; master = the environment (execute stage, consumer, memory).
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_instr;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_data;
  logic                rsp_err;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN/8-1:0]   mem_be;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_instr, req_addr, req_wdata, rsp_ready, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_instr, req_addr, req_wdata, rsp_ready, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store steering over a two-word window,
// plus load shift/merge and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  size_e                      i_size,
  input  logic [$clog2(XLEN/8)-1:0]  i_off,
  input  logic                       i_signed,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic [XLEN-1:0]            i_rdata_lo,
  input  logic [XLEN-1:0]            i_rdata_hi,
  output logic [XLEN/8-1:0]          o_be_lo,
  output logic [XLEN/8-1:0]          o_be_hi,
  output logic [XLEN-1:0]            o_wdata_lo,
  output logic [XLEN-1:0]            o_wdata_hi,
  output logic [XLEN-1:0]            o_ldata
);
  localparam int NB   = XLEN / 8;
  localparam int BW2  = 2 * NB;
  localparam int IDXW = $clog2(XLEN);

  logic [BW2-1:0]    w_mask2;
  logic [BW2-1:0]    w_bfull;
  logic [2*XLEN-1:0] w_wfull;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_keep;
  logic [IDXW-1:0]   w_top;

  // Byte-enable and store-data steering; the upper half lands in the next word
  always_comb begin
    case (i_size)
      SZ_B:    w_mask2 = BW2'(8'h01);
      SZ_H:    w_mask2 = BW2'(8'h03);
      SZ_W:    w_mask2 = BW2'(8'h0F);
      SZ_D:    w_mask2 = BW2'(8'hFF);
      default: w_mask2 = BW2'(8'h01);
    endcase
    w_bfull    = w_mask2 << i_off;
    w_wfull    = {{XLEN{1'b0}}, i_wdata} << {i_off, 3'b000};
    o_be_lo    = w_bfull[NB-1:0];
    o_be_hi    = w_bfull[BW2-1:NB];
    o_wdata_lo = w_wfull[XLEN-1:0];
    o_wdata_hi = w_wfull[2*XLEN-1:XLEN];
  end

  // Load alignment: merge both words, shift down, then extend from the size's top bit
  always_comb begin
    w_shifted = XLEN'({i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000});
    case (i_size)
      SZ_B:    w_top = IDXW'(7);
      SZ_H:    w_top = IDXW'(15);
      SZ_W:    w_top = IDXW'(31);
      SZ_D:    w_top = IDXW'(XLEN - 1);
      default: w_top = IDXW'(XLEN - 1);
    endcase
    w_keep  = {XLEN{1'b1}} >> (IDXW'(XLEN - 1) - w_top);
    o_ldata = (w_shifted & w_keep) | ((i_signed && w_shifted[w_top]) ? ~w_keep : {XLEN{1'b0}});
  end

endmodule

// File: rtl/lsu_pipe.sv
// Multi-cycle load/store unit: accept, bus access with timeout, aligned response.
// Optional LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two bus transactions.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] TO_LAST = CNTW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic TO_EN = (ACK_TIMEOUT > 0);
  localparam logic IS64  = (XLEN == 64);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  state_e            r_state, w_nxt_state;
  size_e             r_size, w_nxt_size;
  logic              r_signed, w_nxt_signed;
  logic [OFFW-1:0]   r_off, w_nxt_off;
  logic [XLEN-1:0]   r_wdata, w_nxt_wdata;
  logic              r_split, w_nxt_split;
  logic [XLEN-1:0]   r_lo_rdata, w_nxt_lo_rdata;
  logic [CNTW-1:0]   r_cnt, w_nxt_cnt;
  logic              r_req_ready, w_nxt_req_ready;
  logic              r_rsp_valid, w_nxt_rsp_valid;
  logic [XLEN-1:0]   r_rsp_data, w_nxt_rsp_data;
  logic              r_rsp_err, w_nxt_rsp_err;
  logic              r_mem_req, w_nxt_mem_req;
  logic              r_mem_we, w_nxt_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_nxt_mem_addr;
  logic [NB-1:0]     r_mem_be, w_nxt_mem_be;
  logic [XLEN-1:0]   r_mem_wdata, w_nxt_mem_wdata;

  dec_t              w_dec;
  logic              w_accept;
  logic              w_in_idle;
  logic              w_cross;
  size_e             w_a_size;
  logic [OFFW-1:0]   w_a_off;
  logic              w_a_signed;
  logic [XLEN-1:0]   w_a_wdata;
  logic [XLEN-1:0]   w_a_rdata_lo;
  logic [XLEN-1:0]   w_a_rdata_hi;
  logic [NB-1:0]     w_be_lo, w_be_hi;
  logic [XLEN-1:0]   w_wdata_lo, w_wdata_hi;
  logic [XLEN-1:0]   w_ldata;

  assign w_dec     = lsu_decode(bus.req_instr, IS64);
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = bus.req_valid & r_req_ready;

  // The aligner sees the incoming request while idle and the latched operation afterwards.
  assign w_a_size     = w_in_idle ? w_dec.size : r_size;
  assign w_a_off      = w_in_idle ? bus.req_addr[OFFW-1:0] : r_off;
  assign w_a_signed   = w_in_idle ? w_dec.sgn : r_signed;
  assign w_a_wdata    = w_in_idle ? bus.req_wdata : r_wdata;
  assign w_a_rdata_lo = (r_state == ST_ACCESS2) ? r_lo_rdata : bus.mem_rdata;
  assign w_a_rdata_hi = (r_state == ST_ACCESS2) ? bus.mem_rdata : {XLEN{1'b0}};
  assign w_cross      = |w_be_hi;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_size     (w_a_size),
    .i_off      (w_a_off),
    .i_signed   (w_a_signed),
    .i_wdata    (w_a_wdata),
    .i_rdata_lo (w_a_rdata_lo),
    .i_rdata_hi (w_a_rdata_hi),
    .o_be_lo    (w_be_lo),
    .o_be_hi    (w_be_hi),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_ldata    (w_ldata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_size      = r_size;
    w_nxt_signed    = r_signed;
    w_nxt_off       = r_off;
    w_nxt_wdata     = r_wdata;
    w_nxt_split     = r_split;
    w_nxt_lo_rdata  = r_lo_rdata;
    w_nxt_cnt       = r_cnt;
    w_nxt_req_ready = r_req_ready;
    w_nxt_rsp_valid = r_rsp_valid;
    w_nxt_rsp_data  = r_rsp_data;
    w_nxt_rsp_err   = r_rsp_err;
    w_nxt_mem_req   = r_mem_req;
    w_nxt_mem_we    = r_mem_we;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_be    = r_mem_be;
    w_nxt_mem_wdata = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt_req_ready = 1'b0;
          w_nxt_size      = w_dec.size;
          w_nxt_signed    = w_dec.sgn;
          w_nxt_off       = bus.req_addr[OFFW-1:0];
          w_nxt_wdata     = bus.req_wdata;
          w_nxt_split     = w_cross;
          w_nxt_cnt       = '0;
          if (!w_dec.is_mem) begin
            w_nxt_state     = ST_RESP;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_data  = bus.req_wdata;
            w_nxt_rsp_err   = 1'b0;
          end else if (!w_dec.legal || (w_cross && !SPLIT_EN)) begin
            w_nxt_state     = ST_RESP;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_data  = '0;
            w_nxt_rsp_err   = 1'b1;
          end else begin
            w_nxt_state     = ST_ACCESS;
            w_nxt_mem_req   = 1'b1;
            w_nxt_mem_we    = w_dec.is_store;
            w_nxt_mem_addr  = {bus.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            w_nxt_mem_be    = w_be_lo;
            w_nxt_mem_wdata = w_wdata_lo;
          end
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_ACCESS, ST_ACCESS2: begin
        // An ack always beats a timeout landing in the same cycle.
        if (bus.mem_ack) begin
          if ((r_state == ST_ACCESS) && r_split) begin
            w_nxt_state     = ST_ACCESS2;
            w_nxt_lo_rdata  = bus.mem_rdata;
            w_nxt_mem_addr  = r_mem_addr + ADDR_W'(NB);
            w_nxt_mem_be    = w_be_hi;
            w_nxt_mem_wdata = w_wdata_hi;
            w_nxt_cnt       = '0;
          end else begin
            w_nxt_state     = ST_RESP;
            w_nxt_mem_req   = 1'b0;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_err   = 1'b0;
            w_nxt_rsp_data  = r_mem_we ? {XLEN{1'b0}} : w_ldata;
          end
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_nxt_state     = ST_RESP;
          w_nxt_mem_req   = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_err   = 1'b1;
          w_nxt_rsp_data  = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNTW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_nxt_state     = ST_IDLE;
          w_nxt_req_ready = 1'b1;
          w_nxt_rsp_valid = 1'b0;
          w_nxt_rsp_data  = '0;
          w_nxt_rsp_err   = 1'b0;
        end else begin
          w_nxt_state = ST_RESP;
        end
      end
      default: begin
        w_nxt_state     = ST_IDLE;
        w_nxt_req_ready = 1'b1;
        w_nxt_rsp_valid = 1'b0;
        w_nxt_mem_req   = 1'b0;
      end
    endcase
  end

  // Operation context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size      <= SZ_B;
      r_signed    <= 1'b0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_split     <= 1'b0;
      r_lo_rdata  <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_size      <= w_nxt_size;
      r_signed    <= w_nxt_signed;
      r_off       <= w_nxt_off;
      r_wdata     <= w_nxt_wdata;
      r_split     <= w_nxt_split;
      r_lo_rdata  <= w_nxt_lo_rdata;
      r_cnt       <= w_nxt_cnt;
      r_req_ready <= w_nxt_req_ready;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_data  <= w_nxt_rsp_data;
      r_rsp_err   <= w_nxt_rsp_err;
      r_mem_req   <= w_nxt_mem_req;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_be    <= w_nxt_mem_be;
      r_mem_wdata <= w_nxt_mem_wdata;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe (XLEN=32, ACK_TIMEOUT=8): vector table plus
// hand-written sequences for backpressure, timeout, misaligned access and reset.
module tb_lsu_pipe;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdata;
    bit          exp_mem;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[13];

  lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  lsu_pipe #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ACK_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present one request while idle; returns at the negedge after the accepting edge.
  task automatic present(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] wdata);
    chk("idle_req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_instr = instr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("after_take_valid", bus.rsp_valid, 1'b0);
    chk("after_take_ready", bus.req_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    present(v.instr, v.addr, v.wdata);
    chk("vec_mem_req", bus.mem_req, v.exp_mem);
    if (v.exp_mem) begin
      chk("vec_addr", bus.mem_addr, v.exp_addr);
      chk("vec_be", bus.mem_be, v.exp_be);
      chk("vec_we", bus.mem_we, v.exp_we);
      if (v.exp_we) chk("vec_wdata", bus.mem_wdata, v.exp_wdata);
      for (int i = 0; i < v.dly; i++) begin
        @(negedge clk);
        chk("vec_wait_req", bus.mem_req, 1'b1);
        chk("vec_wait_addr", bus.mem_addr, v.exp_addr);
        chk("vec_wait_valid", bus.rsp_valid, 1'b0);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = v.rdata;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      chk("vec_req_drop", bus.mem_req, 1'b0);
    end
    chk("vec_rsp_valid", bus.rsp_valid, 1'b1);
    chk("vec_rsp_data", bus.rsp_data, v.exp_data);
    chk("vec_rsp_err", bus.rsp_err, v.exp_err);
    take_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    //          instr         addr          wdata         dly rdata         mem  we   addr          be       wdata         data          err
    vecs[0]  = '{32'h00000003, 32'h00001003, 32'h0,        0, 32'h80000000, 1'b1, 1'b0, 32'h00001000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[1]  = '{32'h00004003, 32'h00001003, 32'h0,        0, 32'h80000000, 1'b1, 1'b0, 32'h00001000, 4'b1000, 32'h0,        32'h00000080, 1'b0};
    vecs[2]  = '{32'h00001023, 32'h00001002, 32'h0000BEEF, 1, 32'h0,        1'b1, 1'b1, 32'h00001000, 4'b1100, 32'hBEEF0000, 32'h0,        1'b0};
    vecs[3]  = '{32'h00001003, 32'h00002002, 32'h0,        0, 32'h80011234, 1'b1, 1'b0, 32'h00002000, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[4]  = '{32'h00005003, 32'h00002000, 32'h0,        1, 32'h1234F00D, 1'b1, 1'b0, 32'h00002000, 4'b0011, 32'h0,        32'h0000F00D, 1'b0};
    vecs[5]  = '{32'h00002003, 32'h00003000, 32'h0,        2, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00003000, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{32'h00000023, 32'h00004001, 32'h000000A5, 0, 32'h0,        1'b1, 1'b1, 32'h00004000, 4'b0010, 32'h0000A500, 32'h0,        1'b0};
    vecs[7]  = '{32'h00002023, 32'h00004004, 32'hCAFEF00D, 0, 32'h0,        1'b1, 1'b1, 32'h00004004, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[8]  = '{32'h00003003, 32'h00005000, 32'h0,        0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{32'h00003023, 32'h00005000, 32'h11111111, 0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{32'h00000033, 32'h00000000, 32'h55AA55AA, 0, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h55AA55AA, 1'b0};
    vecs[11] = '{32'h00000003, 32'h00001001, 32'h0,        0, 32'h00007F00, 1'b1, 1'b0, 32'h00001000, 4'b0010, 32'h0,        32'h0000007F, 1'b0};
    vecs[12] = '{32'h00002003, 32'h00007000, 32'h0,        7, 32'h13579BDF, 1'b1, 1'b0, 32'h00007000, 4'b1111, 32'h0,        32'h13579BDF, 1'b0};

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_instr = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_be", bus.mem_be, 4'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // LW with a 3-cycle ack delay and 2 cycles of response backpressure
    present(32'h00002003, 32'h00006008, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", bus.mem_req, 1'b1);
      chk("bp_addr", bus.mem_addr, 32'h00006008);
      chk("bp_be", bus.mem_be, 4'b1111);
      chk("bp_we", bus.mem_we, 1'b0);
      @(negedge clk);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_data", bus.rsp_data, 32'h0BADF00D);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_instr = 32'h00000033;
    bus.req_wdata = 32'h00C0FFEE;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_no_same_accept", bus.rsp_valid, 1'b0);
    chk("bp_ready_after", bus.req_ready, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_next_valid", bus.rsp_valid, 1'b1);
    chk("bp_next_data", bus.rsp_data, 32'h00C0FFEE);
    take_rsp();

    // Never-acked load times out after 8 request cycles
    present(32'h00002003, 32'h00008000, 32'h0);
    cnt = 0;
    while (bus.mem_req && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_req_cycles", cnt, 8);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_rsp_err", bus.rsp_err, 1'b1);
    chk("to_rsp_data", bus.rsp_data, 32'h0);
    take_rsp();

    // Word-crossing LW at 0x1002
    present(32'h00002003, 32'h00001002, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("mis_req1", bus.mem_req, 1'b1);
    chk("mis_addr1", bus.mem_addr, 32'h00001000);
    chk("mis_be1", bus.mem_be, 4'b1100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAABB0000;
    @(negedge clk);
    chk("mis_req2", bus.mem_req, 1'b1);
    chk("mis_addr2", bus.mem_addr, 32'h00001004);
    chk("mis_be2", bus.mem_be, 4'b0011);
    chk("mis_mid_valid", bus.rsp_valid, 1'b0);
    bus.mem_rdata = 32'h0000CCDD;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    chk("mis_req_drop", bus.mem_req, 1'b0);
    chk("mis_rsp_data", bus.rsp_data, 32'hCCDDAABB);
    chk("mis_rsp_err", bus.rsp_err, 1'b0);
`else
    chk("mis_no_req", bus.mem_req, 1'b0);
    chk("mis_rsp_data", bus.rsp_data, 32'h0);
    chk("mis_rsp_err", bus.rsp_err, 1'b1);
`endif
    chk("mis_rsp_valid", bus.rsp_valid, 1'b1);
    take_rsp();

    // Asynchronous reset in the middle of an access
    present(32'h00002003, 32'h00009000, 32'h0);
    chk("rst_mid_req_before", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", bus.mem_req, 1'b0);
    chk("rst_mid_ready", bus.req_ready, 1'b1);
    chk("rst_mid_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    present(32'h00000033, 32'h0, 32'h00001234);
    chk("post_rst_valid", bus.rsp_valid, 1'b1);
    chk("post_rst_data", bus.rsp_data, 32'h00001234);
    chk("post_rst_no_req", bus.mem_req, 1'b0);
    take_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
